// File: rtl/ascon_permutation_iter.sv
// -----------------------------------------------------------------------------
// ascon_permutation_iter
//
// Iterative Ascon permutation p^n over the 320-bit state, one round per clock.
// Each round applies constant addition (pc), the bitsliced 5-bit S-box layer
// (ps) and the linear diffusion layer (pl). Only one permutation is in flight
// at a time.
//
// Word mapping: x_k = state[64*k +: 64], so x0 occupies bits [63:0] and
// x4 occupies bits [319:256].
//
// Ports:
//   clk_i     in   clock, rising edge
//   rst_i     in   synchronous active-high reset
//   start_i   in   request valid (accepted only in IDLE)
//   ready_o   out  engine idle, can accept a request
//   rounds_i  in   round count n (13..15 treated as 12), sampled at accept
//   state_i   in   input state, sampled at accept
//   valid_o   out  result valid (DONE)
//   ready_i   in   consumer takes the result
//   state_o   out  internal state register
//   busy_o    out  high while running or holding a result
//
// Parameter:
//   ZEROIZE   when 1, the state register clears on the output handshake
// -----------------------------------------------------------------------------
module ascon_permutation_iter #(
    parameter bit ZEROIZE = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    output logic         ready_o,
    input  logic [3:0]   rounds_i,
    input  logic [319:0] state_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [319:0] state_o,
    output logic         busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    // Rotation amounts of the linear layer, indexed by word.
    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

    fsm_t           fsm_reg, fsm_next;
    logic [3:0]     cnt_reg, cnt_next;
    logic [319:0]   state_reg, state_next;

    logic [3:0]     rounds_clamped;
    logic [7:0]     round_const;

    logic [63:0]    x_w [5];   // current words
    logic [63:0]    a_w [5];   // after constant addition and input mixing
    logic [63:0]    t_w [5];   // chi terms
    logic [63:0]    c_w [5];   // after chi
    logic [63:0]    s_w [5];   // after output mixing (end of ps)
    logic [63:0]    l_w [5];   // after pl
    logic [319:0]   round_out;

    function automatic logic [63:0] ror64(input logic [63:0] v, input int r);
        return (v >> r) | (v << (64 - r));
    endfunction

    // Constant for round index i: high nibble counts down from 0xf, low
    // nibble counts up from 0 (index 0 -> 0xf0, index 11 -> 0x4b).
    assign round_const    = {4'hf - cnt_reg, cnt_reg};
    assign rounds_clamped = (rounds_i > 4'd12) ? 4'd12 : rounds_i;

    // Input mixing of ps, with the round constant folded into x2.
    always_comb begin
        a_w[0] = x_w[0] ^ x_w[4];
        a_w[1] = x_w[1];
        a_w[2] = x_w[2] ^ {56'd0, round_const} ^ x_w[1];
        a_w[3] = x_w[3];
        a_w[4] = x_w[4] ^ x_w[3];
    end

    // Output mixing of ps.
    always_comb begin
        s_w[0] = c_w[0] ^ c_w[4];
        s_w[1] = c_w[1] ^ c_w[0];
        s_w[2] = ~c_w[2];
        s_w[3] = c_w[3] ^ c_w[2];
        s_w[4] = c_w[4];
    end

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_word
            assign x_w[gi] = state_reg[64*gi +: 64];
            assign t_w[gi] = ~a_w[gi] & a_w[(gi + 1) % 5];
            assign c_w[gi] = a_w[gi] ^ t_w[(gi + 1) % 5];
            assign l_w[gi] = s_w[gi] ^ ror64(s_w[gi], ROT_A[gi])
                                     ^ ror64(s_w[gi], ROT_B[gi]);
            assign round_out[64*gi +: 64] = l_w[gi];
        end
    endgenerate

    always_comb begin
        fsm_next   = fsm_reg;
        cnt_next   = cnt_reg;
        state_next = state_reg;
        case (fsm_reg)
            IDLE: begin
                if (start_i) begin
                    state_next = state_i;
                    // Start part-way into the constant schedule so that the
                    // last round always uses index 11.
                    cnt_next   = 4'd12 - rounds_clamped;
                    fsm_next   = (rounds_clamped == 4'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                state_next = round_out;
                cnt_next   = cnt_reg + 4'd1;
                if (cnt_reg == 4'd11) begin
                    fsm_next = DONE;
                end
            end
            DONE: begin
                if (ready_i) begin
                    fsm_next = IDLE;
                    if (ZEROIZE) begin
                        state_next = '0;
                    end
                end
            end
            default: begin
                fsm_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_reg   <= IDLE;
            cnt_reg   <= 4'd0;
            state_reg <= '0;
        end else begin
            fsm_reg   <= fsm_next;
            cnt_reg   <= cnt_next;
            state_reg <= state_next;
        end
    end

    assign ready_o = (fsm_reg == IDLE);
    assign valid_o = (fsm_reg == DONE);
    assign busy_o  = (fsm_reg == RUN) || (fsm_reg == DONE);
    assign state_o = state_reg;

endmodule

// File: doc/ascon_permutation_iter.md
Name: ascon_permutation_iter

Overview:
- Iterative Ascon permutation engine: p^n on the 320-bit state_t, one round per clock.
- Drives the round index into the existing constant-addition stage, then the substitution layer (ps) and the linear diffusion layer (pl).
- Accepts a state and round count over a valid/ready input handshake; returns the permuted state over a valid/ready output handshake.
- Sits between the Ascon mode controller (init / associated data / finalize) and the state register file.

Parameters:
- ZEROIZE, 0: when 1, the internal state register clears to 0 on the output handshake.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  input valid: request a permutation.
- ready_o  output  1  engine can accept a request (IDLE only).
- rounds_i  input  4  number of rounds n; sampled at accept.
- state_i  input  320 (state_t)  input state; sampled at accept.
- valid_o  output  1  result valid (DONE only).
- ready_i  input  1  consumer accepts the result.
- state_o  output  320 (state_t)  internal state register, driven directly.
- busy_o  output  1  high in RUN and DONE.

Behaviour:
- Reset (rst_i high at a clock edge):
  - FSM goes to IDLE; round counter = 0; state register = 0.
  - ready_o = 1, valid_o = 0, busy_o = 0 from the next cycle.
  - Reset wins over every other event, including a reset mid-RUN or mid-DONE; any in-flight result is discarded.
- FSM states:
  - IDLE:
    - ready_o = 1.
    - Accept = start_i & ready_o: state register <= state_i.
    - Round counter <= 12 - n, where n = min(rounds_i, 12); rounds_i values 13..15 are treated as 12.
    - n = 0: go to DONE (state passes through unchanged). Otherwise go to RUN.
  - RUN:
    - Each cycle: state <= pl(ps(pc(state, cnt))); cnt <= cnt + 1.
    - When cnt == 11 is being processed, go to DONE.
    - start_i is ignored in RUN.
  - DONE:
    - valid_o = 1; state_o is held stable until the handshake.
    - On valid_o & ready_i: go to IDLE; if ZEROIZE = 1, state register <= 0.
    - ready_o = 0 in DONE, so a new request is accepted no earlier than the cycle after the output handshake.
- Round constant:
  - The constant for index cnt comes from the existing constant-addition stage.
  - Index 0 = 0xf0, index 11 = 0x4b; the constant is XORed into the low byte of x2.
  - p^12 uses indices 0..11, p^8 uses 4..11, p^6 uses 6..11.
- ps (bitsliced 5-bit S-box, applied per bit column), in order:
  1. x0 ^= x4; x4 ^= x3; x2 ^= x1.
  2. t_i = ~x_i & x_(i+1 mod 5).
  3. x_i ^= t_(i+1 mod 5).
  4. x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2.
- pl (right rotations, 64-bit words): xk ^= ror(xk, a) ^ ror(xk, b), with (a, b):
  - x0: (19, 28)
  - x1: (61, 39)
  - x2: (1, 6)
  - x3: (10, 17)
  - x4: (7, 41)
- Latency: accept at cycle t -> valid_o high from cycle t + n + 1.
  - n = 12: 13 cycles. n = 0: 1 cycle.
- Word mapping: state[0] = x0 ... state[4] = x4.
- Throughput: one permutation in flight at a time; no pipelining.

Test Plan:
- Reset, then idle: ready_o = 1, valid_o = 0, busy_o = 0, state_o = 0.
- All-zero state_i, rounds_i = 1, ready_i = 1 -> valid_o high at t + 2 with:
  - x0 = 0x000964B00000004B
  - x1 = 0x0000000096000213
  - x2 = 0x53FFFFFFFFFFFF90
  - x3 = 0x12E580000000004B
  - x4 = 0
- rounds_i = 12, 6 and 8 on random states -> state_o matches the team golden software model; valid_o at t + 13, t + 7 and t + 9 respectively; rounds_i = 15 gives the same result as 12.
- rounds_i = 0 -> valid_o at t + 1 with state_o == state_i.
- ready_i held low for 5 cycles in DONE -> valid_o and state_o stable; start_i pulses ignored; IDLE entered the cycle after ready_i rises. With ZEROIZE = 1, state_o = 0 after the handshake.
- rst_i asserted at RUN cycle 4 of p^12 -> next cycle is IDLE, state_o = 0, no valid_o pulse; a fresh request then completes correctly.
